pipe_dmem_responder: RTL

- Data-memory responder for the pipelined CPU's load/store port. The CPU is the initiator and this block is the target.
- Accepts one request at a time on a valid/ready handshake and services it against an internal word-addressed array.
- Returns a response after a fixed, parameterised latency, also on a valid/ready handshake.
- Lets the CPU and its bench exercise load/store stalls and backpressure, instead of relying on a zero-latency memory.

---
 rtl/pipe_dmem_responder.sv | 66 ++++++
 1 files changed

// File: rtl/pipe_dmem_responder.sv
// pipe_dmem_responder: fixed-latency data-memory target for the CPU load/store port
//   clk        rising-edge clock
//   clrn       synchronous active-low reset; clears state and the whole array
//   req_*      request channel (valid/ready), byte address, store data and lane enables
//   rsp_*      response channel (valid/ready), load data and error flag
module pipe_dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [31:0] mem [2**ADDR_W];
  logic [3:0] cnt;
  logic [31:0] rdata;
  logic err_q, acc, err;
  logic [ADDR_W-1:0] idx;
  assign acc = req_valid & req_ready;
  assign err = (req_addr[1:0] != 2'b0) | (req_addr[31:ADDR_W+2] != '0);
  assign idx = req_addr[ADDR_W+1:2];
  // gated by clrn so nothing is accepted in the reset cycle itself
  assign req_ready = clrn & (state == IDLE);
  assign rsp_valid = state == RESP;
  // the captured result stays internal until the response is presented
  assign rsp_rdata = rsp_valid ? rdata : '0;
  assign rsp_err = rsp_valid & err_q;
  always_comb
    state_n = acc ? (LATENCY == 1 ? RESP : WAIT) :
              (state == WAIT && cnt == 4'd0) ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (acc) begin
        cnt <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
        err_q <= err;
        rdata <= (err || req_we) ? '0 : mem[idx];
        if (req_we && !err)
          for (int b = 0; b < 4; b++)
            if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end else if (rsp_valid && rsp_ready) begin
        rdata <= '0;
        err_q <= 1'b0;
      end
    end
  end
endmodule
